// File: rtl/dcache_direct_mapped.sv
// ---------------------------------------------------------------------------
// dcache_direct_mapped
//   Direct-mapped, write-back, write-allocate data cache sitting between the
//   cpu byte-wide data port and a block-organised data memory with a 32-bit
//   block bus.
//   - Hits are served with no stall: reads are combinational and writes
//     commit at the next posedge.
//   - A miss stalls the cpu through BUSYWAIT. A dirty victim is written back
//     first, then the requested block is fetched.
//
// Ports
//   CLK            system clock, all state changes on posedge
//   RESET          asynchronous active-low reset
//   READ / WRITE   cpu load / store request (both high is treated as a store)
//   ADDRESS        cpu byte address = {tag, index, offset}
//   WRITEDATA      cpu store byte
//   READDATA       cpu load byte; holds its last value when not reading a hit
//   BUSYWAIT       stall to cpu
//   MEM_READ       memory block read request
//   MEM_WRITE      memory block write request
//   MEM_ADDRESS    memory block address = {tag, index}
//   MEM_WRITEDATA  victim block, byte0 in [7:0]
//   MEM_READDATA   fetched block, byte0 in [7:0]
//   MEM_BUSYWAIT   memory busy; low at an edge marks transfer completion
// ---------------------------------------------------------------------------
module dcache_direct_mapped #(
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_BITS    = 8 - INDEX_BITS - OFFSET_BITS
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           READ,
    input  logic                           WRITE,
    input  logic [7:0]                     ADDRESS,
    input  logic [7:0]                     WRITEDATA,
    output logic [7:0]                     READDATA,
    output logic                           BUSYWAIT,
    output logic                           MEM_READ,
    output logic                           MEM_WRITE,
    output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
    output logic [31:0]                    MEM_WRITEDATA,
    input  logic [31:0]                    MEM_READDATA,
    input  logic                           MEM_BUSYWAIT
);

    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           data_q  [LINES];
    logic [31:0]           data_d  [LINES];
    logic [TAG_BITS-1:0]   tag_q   [LINES];
    logic [TAG_BITS-1:0]   tag_d   [LINES];
    logic [LINES-1:0]      valid_q, valid_d;
    logic [LINES-1:0]      dirty_q, dirty_d;
    logic [7:0]            readdata_q, readdata_d;

    logic [TAG_BITS-1:0]    addr_tag;
    logic [INDEX_BITS-1:0]  idx;
    logic [OFFSET_BITS-1:0] off;
    logic [OFFSET_BITS+2:0] bit_sel;
    logic                   hit;
    logic                   req;
    logic                   is_read;

    assign {addr_tag, idx, off} = ADDRESS;
    assign bit_sel = {off, 3'b000};
    assign hit     = valid_q[idx] && (tag_q[idx] == addr_tag);
    assign req     = READ || WRITE;
    // A simultaneous READ and WRITE is handled as a store only.
    assign is_read = READ && !WRITE;

    // Gated by RESET so an aborted miss releases the cpu immediately even
    // while its request is still held.
    assign BUSYWAIT = RESET && req && !((state_q == IDLE) && hit);

    // Read data is combinational on a read hit, otherwise the last value is held.
    always_comb begin
        READDATA = readdata_q;
        if (is_read && hit) begin
            READDATA = data_q[idx][bit_sel +: 8];
        end
        readdata_d = READDATA;
    end

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        tag_d         = tag_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = {addr_tag, idx};
        MEM_WRITEDATA = data_q[idx];

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (WRITE) begin
                            data_d[idx][bit_sel +: 8] = WRITEDATA;
                            dirty_d[idx]              = 1'b1;
                        end
                    end else if (valid_q[idx] && dirty_q[idx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                MEM_WRITE   = 1'b1;
                MEM_ADDRESS = {tag_q[idx], idx};
                if (!MEM_BUSYWAIT) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    data_d[idx]  = MEM_READDATA;
                    tag_d[idx]   = addr_tag;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = UPDATE;
                end
            end
            UPDATE: begin
                // One settling cycle; the request resolves as a hit in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            readdata_q <= readdata_d;
        end
    end

    // Block data and tags are meaningless until the valid bit is set, so
    // they carry no reset.
    always_ff @(posedge CLK) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// ---------------------------------------------------------------------------
// tb_dcache_direct_mapped
//   Self-checking bench for dcache_direct_mapped. A behavioural block memory
//   answers MEM_READ in L cycles and MEM_WRITE in L+1 cycles (a block write
//   needs one extra cycle to commit). Each cpu request pushes its expected
//   outcome onto a scoreboard queue; the entry is popped and compared when
//   BUSYWAIT releases the request.
// ---------------------------------------------------------------------------
module tb_dcache_direct_mapped;

    localparam int L = 5;

    logic        clk;
    logic        rst_n;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_busy;
    logic        mem_rd;
    logic        mem_wr;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_busy;

    dcache_direct_mapped dut (
        .CLK           (clk),
        .RESET         (rst_n),
        .READ          (cpu_rd),
        .WRITE         (cpu_wr),
        .ADDRESS       (cpu_addr),
        .WRITEDATA     (cpu_wdata),
        .READDATA      (cpu_rdata),
        .BUSYWAIT      (cpu_busy),
        .MEM_READ      (mem_rd),
        .MEM_WRITE     (mem_wr),
        .MEM_ADDRESS   (mem_addr),
        .MEM_WRITEDATA (mem_wdata),
        .MEM_READDATA  (mem_rdata),
        .MEM_BUSYWAIT  (mem_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- block memory model ----------------
    logic [31:0] mem [0:63];
    int          mcnt;
    int          mlat;

    assign mlat      = mem_wr ? (L + 1) : L;
    assign mem_busy  = (mem_rd || mem_wr) && (mcnt < mlat - 1);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_rd || mem_wr) begin
            if (mcnt >= mlat - 1) begin
                mcnt <= 0;
                if (mem_wr) mem[mem_addr] <= mem_wdata;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    // ---------------- checking ----------------
    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          busy;
        logic        chk_rd;
        logic [7:0]  rdata;
        logic        exp_mrd;
        logic [5:0]  mrd_addr;
        logic        exp_mwr;
        logic [5:0]  mwr_addr;
        logic [31:0] mwr_data;
    } exp_t;

    exp_t sb[$];

    // Drive one cpu request, follow it to completion and score it.
    // Starts and ends just after a posedge.
    task automatic do_req(input string name, input logic rd, input logic wr,
                          input logic [7:0] addr, input logic [7:0] wdata,
                          input int busy, input logic chk_rd, input logic [7:0] rdata,
                          input logic emrd, input logic [5:0] mrda,
                          input logic emwr, input logic [5:0] mwra, input logic [31:0] mwrd);
        exp_t        e;
        exp_t        x;
        int          cyc;
        logic        done;
        logic        saw_rd, saw_wr, both;
        int          first_rd, first_wr;
        logic [5:0]  rd_a, wr_a;
        logic [31:0] wr_d;
        logic [7:0]  got_rdata;

        e.busy = busy;   e.chk_rd = chk_rd; e.rdata = rdata;
        e.exp_mrd = emrd; e.mrd_addr = mrda;
        e.exp_mwr = emwr; e.mwr_addr = mwra; e.mwr_data = mwrd;
        sb.push_back(e);

        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
        cyc = 0; done = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0; both = 1'b0;
        first_rd = 1000; first_wr = 1000; rd_a = '0; wr_a = '0; wr_d = '0;
        got_rdata = '0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (mem_rd && mem_wr) both = 1'b1;
            if (mem_rd && !saw_rd) begin saw_rd = 1'b1; first_rd = k; rd_a = mem_addr; end
            if (mem_wr && !saw_wr) begin saw_wr = 1'b1; first_wr = k; wr_a = mem_addr; wr_d = mem_wdata; end
            if (!cpu_busy) begin
                done = 1'b1;
                got_rdata = cpu_rdata;
            end else begin
                cyc++;
            end
        end
        @(posedge clk);
        #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;

        x = sb.pop_front();
        chk({name, "_done"}, done, 1'b1);
        chk({name, "_busy_cycles"}, cyc, x.busy);
        if (x.chk_rd) chk({name, "_rdata"}, got_rdata, x.rdata);
        chk({name, "_mem_read_seen"}, saw_rd, x.exp_mrd);
        if (x.exp_mrd) chk({name, "_mem_read_addr"}, rd_a, x.mrd_addr);
        chk({name, "_mem_write_seen"}, saw_wr, x.exp_mwr);
        if (x.exp_mwr) begin
            chk({name, "_wb_addr"}, wr_a, x.mwr_addr);
            chk({name, "_wb_data"}, wr_d, x.mwr_data);
            chk({name, "_wb_before_fetch"}, first_wr < first_rd, 1'b1);
        end
        chk({name, "_rd_wr_exclusive"}, both, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int viol;
        n_chk = 0; n_pass = 0; mcnt = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEADBEEF;
        mem[6'h09] = 32'hDDCCBBAA;
        mem[6'h29] = 32'h44332211;
        mem[6'h12] = 32'h88776655;

        rst_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        #12;
        chk("rst_busywait",  cpu_busy,  1'b0);
        chk("rst_mem_read",  mem_rd,    1'b0);
        chk("rst_mem_write", mem_wr,    1'b0);
        chk("rst_readdata",  cpu_rdata, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean miss, then hits on the filled line.
        do_req("rd25_miss", 1, 0, 8'h25, 8'h00, L + 2, 1, 8'hBB, 1, 6'h09, 0, 6'h00, 32'h0);
        do_req("rd27_hit",  1, 0, 8'h27, 8'h00, 0,     1, 8'hDD, 0, 6'h00, 0, 6'h00, 32'h0);
        do_req("wr24_hit",  0, 1, 8'h24, 8'h11, 0,     0, 8'h00, 0, 6'h00, 0, 6'h00, 32'h0);
        do_req("rd24_hit",  1, 0, 8'h24, 8'h00, 0,     1, 8'h11, 0, 6'h00, 0, 6'h00, 32'h0);
        // Dirty victim: writeback then fetch.
        do_req("rdA5_dirty", 1, 0, 8'hA5, 8'h00, 2 * L + 3, 1, 8'h22, 1, 6'h29, 1, 6'h09, 32'hDDCCBB11);
        // Write miss allocates the line, then the store lands in it.
        do_req("wr4A_miss", 0, 1, 8'h4A, 8'h5C, L + 2, 0, 8'h00, 1, 6'h12, 0, 6'h00, 32'h0);
        do_req("rd4A_hit",  1, 0, 8'h4A, 8'h00, 0,     1, 8'h5C, 0, 6'h00, 0, 6'h00, 32'h0);
        do_req("rd4B_hit",  1, 0, 8'h4B, 8'h00, 0,     1, 8'h88, 0, 6'h00, 0, 6'h00, 32'h0);

        // Reset in the middle of a fetch.
        cpu_rd = 1'b1; cpu_addr = 8'h45;
        repeat (3) @(negedge clk);
        chk("midfetch_mem_read", mem_rd,   1'b1);
        chk("midfetch_addr",     mem_addr, 6'h11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_read",  mem_rd,   1'b0);
        chk("abort_mem_write", mem_wr,   1'b0);
        chk("abort_busywait",  cpu_busy, 1'b0);
        @(posedge clk);
        #1;
        cpu_rd = 1'b0; rst_n = 1'b1;

        // Valid bits were cleared, so this misses again; memory now holds the
        // block written back earlier.
        do_req("rd25_after_rst", 1, 0, 8'h25, 8'h00, L + 2, 1, 8'hBB, 1, 6'h09, 0, 6'h00, 32'h0);
        do_req("rd24_after_rst", 1, 0, 8'h24, 8'h00, 0,     1, 8'h11, 0, 6'h00, 0, 6'h00, 32'h0);

        // Long idle period.
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (cpu_busy || mem_rd || mem_wr) viol++;
        end
        chk("idle_quiet", viol, 0);
        @(posedge clk);
        #1;
        do_req("rd27_after_idle", 1, 0, 8'h27, 8'h00, 0, 1, 8'hDD, 0, 6'h00, 0, 6'h00, 32'h0);

        // READ and WRITE together behave as a store.
        do_req("rdwr26", 1, 1, 8'h26, 8'h55, 0, 0, 8'h00, 0, 6'h00, 0, 6'h00, 32'h0);
        do_req("rd26",   1, 0, 8'h26, 8'h00, 0, 1, 8'h55, 0, 6'h00, 0, 6'h00, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dcache_direct_mapped.md
Name: dcache_direct_mapped

Overview:
- Direct-mapped, write-back, write-allocate data cache between the cpu data port (READ, WRITE, ADDRESS, WRITEDATA, READDATA, BUSYWAIT) and the block-organised data memory.
- Hits are served with no stall.
- Misses stall the cpu through BUSYWAIT while a finite state machine writes back the dirty victim block and then fetches the requested block over a 32-bit memory bus.

Parameters:
- INDEX_BITS, 3, log2 of number of cache lines (default 8 lines).
- OFFSET_BITS, 2, log2 of bytes per block (fixed at 4 bytes = 32-bit block; not to be changed).
- TAG_BITS, 8-INDEX_BITS-OFFSET_BITS, tag width (default 3).

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- RESET  input  1  asynchronous, active-low reset (RESET==0 resets).
- READ  input  1  cpu load request.
- WRITE  input  1  cpu store request.
- ADDRESS  input  8  cpu byte address = {tag, index, offset}.
- WRITEDATA  input  8  cpu store byte.
- READDATA  output  8  cpu load byte.
- BUSYWAIT  output  1  stall to cpu.
- MEM_READ  output  1  memory block read request.
- MEM_WRITE  output  1  memory block write request.
- MEM_ADDRESS  output  6  memory block address = {tag, index}.
- MEM_WRITEDATA  output  32  victim block, byte0 in [7:0].
- MEM_READDATA  input  32  fetched block, byte0 in [7:0].
- MEM_BUSYWAIT  input  1  memory busy.

Behaviour:
- Storage per line: 4-byte data, tag, valid, dirty.
- Address split: tag=ADDRESS[7:5], index=ADDRESS[4:2], offset=ADDRESS[1:0].
- hit = valid[index] && tag[index]==ADDRESS tag (combinational).
- Reset (RESET low, async):
  - state=IDLE; all valid and dirty bits cleared; data and tags don't-care.
  - MEM_READ=0, MEM_WRITE=0, BUSYWAIT=0, READDATA=0.
  - Reset asserted mid-miss aborts the transfer immediately. Dirty data is lost.
- BUSYWAIT = (READ|WRITE) && !(state==IDLE && hit). Combinational, so it rises in the same cycle a missing request appears.
- READDATA = selected byte of line[index] at offset, combinational whenever READ && hit. Otherwise holds its last value.
- Write hit (state IDLE, WRITE, hit): at posedge, byte[offset] of line[index] = WRITEDATA; dirty[index]=1.
- Read and write both asserted is illegal; treat as WRITE.
- States:
  - IDLE:
    - No request, or hit: stay.
    - Miss with valid && dirty victim: go to WRITEBACK.
    - Miss otherwise: go to FETCH.
  - WRITEBACK:
    - MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=line data.
    - At a posedge with MEM_BUSYWAIT==0 (not the entry edge), go to FETCH.
  - FETCH:
    - MEM_READ=1, MEM_ADDRESS={ADDRESS tag, index}.
    - At a posedge with MEM_BUSYWAIT==0 (not the entry edge), capture MEM_READDATA into the line, set tag=ADDRESS tag, valid=1, dirty=0, go to UPDATE.
  - UPDATE:
    - MEM_READ=0, MEM_WRITE=0. Next edge goes to IDLE.
    - The request then resolves as a hit: read data appears, BUSYWAIT falls, and a write is applied at the following posedge.
- MEM_READ and MEM_WRITE are never both 1. Both are 0 in IDLE and UPDATE.
- Memory contract: memory raises MEM_BUSYWAIT before the first edge after the request appears. MEM_BUSYWAIT==0 sampled at an edge marks completion. MEM_READDATA is valid at that edge.
- cpu contract: ADDRESS, WRITEDATA, READ and WRITE are held stable while BUSYWAIT==1. The cpu drops READ/WRITE after BUSYWAIT falls.
- Miss latency (clean victim, memory latency L cycles): BUSYWAIT high for L+2 cycles.
- Dirty miss adds L+1 cycles for the writeback.

Test Plan:
- Reset, then READ ADDRESS=0x25 with memory block 0x09 = 0xDDCCBBAA, L=5:
  - MEM_READ=1 with MEM_ADDRESS=0x09; no MEM_WRITE.
  - BUSYWAIT high for 7 cycles, then READDATA=0xBB.
- After the previous fill, READ 0x27: BUSYWAIT stays 0, READDATA=0xDD the same cycle, no memory request.
- WRITE 0x24 data 0x11 (hit): BUSYWAIT=0, no memory traffic; a subsequent READ 0x24 returns 0x11.
- Then READ 0xA5 (same index, tag 101):
  - Writeback first: MEM_WRITE=1, MEM_ADDRESS=0x09, MEM_WRITEDATA=0xDDCCBB11.
  - Then MEM_READ=1, MEM_ADDRESS=0x29.
  - BUSYWAIT high for 13 cycles at L=5.
- Pull RESET low during FETCH:
  - MEM_READ, MEM_WRITE and BUSYWAIT go to 0 immediately.
  - After release, READ 0x25 misses again (valid cleared) and issues MEM_READ to 0x09.
- READ and WRITE both 0 for many cycles: BUSYWAIT=0, MEM_READ=MEM_WRITE=0, state stays IDLE, no array changes.
